// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

   // RFLAGS in x86 bit order; res_1/res_2/res_3 are the architecturally fixed bits.
   typedef struct packed {
      logic [51:0] rsvd_hi;
      logic        of_flag;
      logic        df_flag;
      logic        if_flag;
      logic        tf_flag;
      logic        sf_flag;
      logic        zf_flag;
      logic        res_3;
      logic        af_flag;
      logic        res_2;
      logic        pf_flag;
      logic        res_1;
      logic        cf_flag;
   } flags_reg;

   // Everything the execute stage hands over for one retiring instruction.
   typedef struct packed {
      logic        enable_writeback;
      logic        jump_flag;
      logic        flags_valid;
      flags_reg    rflags;
      logic [63:0] rip;
      logic [1:0]  dep;
      logic        sim_end;
      logic [63:0] alu_result;
      logic [63:0] alu_ext_result;
      logic [3:0]  reg_byte;
      logic [3:0]  rm_byte;
      logic [7:0]  opcode;
   } exwb_entry_t;

   localparam logic [7:0]  OPC_IMUL     = 8'hF7;
   localparam logic [7:0]  OPC_JE       = 8'h74;
   localparam logic [7:0]  OPC_JNL      = 8'h7D;
   localparam logic [3:0]  RAX_IDX      = 4'd0;
   localparam logic [3:0]  RDX_IDX      = 4'd2;
   localparam logic [1:0]  DEP_REGBYTE  = 2'd2;
   localparam logic [63:0] RFLAGS_RESET = 64'h2;

   // Force the fixed RFLAGS bits to their architectural values.
   function automatic flags_reg sanitize_flags(input flags_reg f);
      flags_reg r;
      r       = f;
      r.res_1 = 1'b1;
      r.res_2 = 1'b0;
      r.res_3 = 1'b0;
      return r;
   endfunction

   // Destination GPR comes from ModRM.reg or ModRM.rm depending on dep.
   function automatic logic [3:0] dest_index(input exwb_entry_t e);
      return (e.dep == DEP_REGBYTE) ? e.reg_byte : e.rm_byte;
   endfunction

endpackage

// File: rtl/mod_writeback_if.sv
// EX/WB handshake bundle: execute is the master, writeback the slave.
interface mod_writeback_if;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_enable_writeback;
   logic        ex_jump_flag;
   logic        ex_flags_valid;
   logic [63:0] ex_rflags;
   logic [63:0] ex_rip;
   logic [1:0]  ex_dep;
   logic        ex_sim_end;
   logic [63:0] ex_alu_result;
   logic [63:0] ex_alu_ext_result;
   logic [3:0]  ex_regByte;
   logic [3:0]  ex_rmByte;
   logic [7:0]  ex_opcode;

   modport master (
      output ex_valid, ex_enable_writeback, ex_jump_flag, ex_flags_valid,
             ex_rflags, ex_rip, ex_dep, ex_sim_end, ex_alu_result,
             ex_alu_ext_result, ex_regByte, ex_rmByte, ex_opcode,
      input  ex_ready
   );

   modport slave (
      input  ex_valid, ex_enable_writeback, ex_jump_flag, ex_flags_valid,
             ex_rflags, ex_rip, ex_dep, ex_sim_end, ex_alu_result,
             ex_alu_ext_result, ex_regByte, ex_rmByte, ex_opcode,
      output ex_ready
   );
endinterface

// File: rtl/wb_fifo.sv
// Small skid FIFO of EX/WB entries. Flush empties it and wins over a
// simultaneous push, so an entry arriving on the flush edge is dropped.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  exwb_entry_t                  push_data,
   input  logic                         pop,
   input  logic                         flush,
   output exwb_entry_t                  head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   exwb_entry_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (int'(count) == DEPTH);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mod_writeback.sv
// Writeback stage: buffers retiring EX results, owns the GPR file and RFLAGS,
// splits IMUL into RAX then RDX writes, resteers fetch on taken JE and latches
// end-of-simulation. Optional macro WB_BYPASS_EN adds fwd_valid/fwd_reg/fwd_data
// mirroring the GPR write of the current cycle.
module mod_writeback
   import wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int NREGS = 16
) (
   input  logic                clk,
   input  logic                reset,
   mod_writeback_if.slave      ex_bus,
   output logic [63:0]         regfile [NREGS],
   output logic [63:0]         rflags_seq,
   output logic                redirect_valid,
   output logic [63:0]         redirect_rip,
   output logic                sim_end,
   output logic [63:0]         retired_count
`ifdef WB_BYPASS_EN
   ,
   output logic                fwd_valid,
   output logic [3:0]          fwd_reg,
   output logic [63:0]         fwd_data
`endif
);

   localparam int CW = $clog2(DEPTH+1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_WR_HI = 1'b1;

   logic [0:0]  state;
   logic [0:0]  state_nxt;

   exwb_entry_t push_entry;
   exwb_entry_t head;
   logic [CW-1:0] fifo_count;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_flush;

   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [63:0] wr_data;
   logic        wr_ok;
   logic        flags_we;
   logic        retire;
   logic        redirect_set;
   logic        end_set;

   assign push_entry.enable_writeback = ex_bus.ex_enable_writeback;
   assign push_entry.jump_flag        = ex_bus.ex_jump_flag;
   assign push_entry.flags_valid      = ex_bus.ex_flags_valid;
   assign push_entry.rflags           = ex_bus.ex_rflags;
   assign push_entry.rip              = ex_bus.ex_rip;
   assign push_entry.dep              = ex_bus.ex_dep;
   assign push_entry.sim_end          = ex_bus.ex_sim_end;
   assign push_entry.alu_result       = ex_bus.ex_alu_result;
   assign push_entry.alu_ext_result   = ex_bus.ex_alu_ext_result;
   assign push_entry.reg_byte         = ex_bus.ex_regByte;
   assign push_entry.rm_byte          = ex_bus.ex_rmByte;
   assign push_entry.opcode           = ex_bus.ex_opcode;

   assign ex_bus.ex_ready = (int'(fifo_count) < DEPTH) && !sim_end;
   assign fifo_push       = ex_bus.ex_valid && ex_bus.ex_ready && !fifo_full;
   assign wr_ok           = wr_en && (int'(wr_idx) < NREGS);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Decide what the head entry does this cycle: which GPR/flags to write,
   // whether it retires, and whether it resteers fetch or ends the run.
   always_comb begin
      state_nxt    = state;
      fifo_pop     = 1'b0;
      fifo_flush   = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = '0;
      wr_data      = '0;
      flags_we     = 1'b0;
      retire       = 1'b0;
      redirect_set = 1'b0;
      end_set      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               flags_we = head.flags_valid;
               if (head.opcode == OPC_IMUL) begin
                  wr_en     = 1'b1;
                  wr_idx    = RAX_IDX;
                  wr_data   = head.alu_result;
                  state_nxt = ST_WR_HI;
               end else begin
                  fifo_pop = 1'b1;
                  retire   = 1'b1;
                  if ((head.opcode != OPC_JE) && (head.opcode != OPC_JNL)) begin
                     wr_en   = head.enable_writeback;
                     wr_idx  = dest_index(head);
                     wr_data = head.alu_result;
                  end
                  if ((head.opcode == OPC_JE) && head.jump_flag) begin
                     redirect_set = 1'b1;
                     fifo_flush   = 1'b1;
                  end
                  if (head.sim_end) begin
                     end_set    = 1'b1;
                     fifo_flush = 1'b1;
                  end
               end
            end
         end
         ST_WR_HI: begin
            wr_en     = 1'b1;
            wr_idx    = RDX_IDX;
            wr_data   = head.alu_ext_result;
            fifo_pop  = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_IDLE;
            if (head.sim_end) begin
               end_set    = 1'b1;
               fifo_flush = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // IMUL sequencing between the RAX and RDX write cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Single-port GPR write; out-of-range destinations are silently dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
      end else if (wr_ok) begin
         regfile[wr_idx] <= wr_data;
      end
   end

   // Architectural flags with the fixed bits normalised on every update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        rflags_seq <= RFLAGS_RESET;
      else if (flags_we) rflags_seq <= sanitize_flags(head.rflags);
   end

   // Resteer pulse, sticky end flag and retirement counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect_valid <= 1'b0;
         redirect_rip   <= '0;
         sim_end        <= 1'b0;
         retired_count  <= '0;
      end else begin
         redirect_valid <= redirect_set;
         if (redirect_set) redirect_rip  <= head.rip;
         if (end_set)      sim_end       <= 1'b1;
         if (retire)       retired_count <= retired_count + 64'd1;
      end
   end

`ifdef WB_BYPASS_EN
   assign fwd_valid = wr_ok;
   assign fwd_reg   = wr_idx;
   assign fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_mod_writeback.sv
// Testbench for mod_writeback: reset, latency, IMUL, back-pressure, taken-jump
// flush, sim_end, reset mid-IMUL, vector table and randomized traffic.
module tb_mod_writeback;
   import wb_pkg::*;

   localparam int DEPTH = 2;
   localparam int NREGS = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] regfile [NREGS];
   logic [63:0] rflags_seq;
   logic        redirect_valid;
   logic [63:0] redirect_rip;
   logic        sim_end;
   logic [63:0] retired_count;
`ifdef WB_BYPASS_EN
   logic        fwd_valid;
   logic [3:0]  fwd_reg;
   logic [63:0] fwd_data;
`endif

   int total = 0;
   int bad = 0;
   int redirect_pulses = 0;
   bit saw_stall = 0;

   mod_writeback_if ex_bus();

   mod_writeback #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
      .clk            (clk),
      .reset          (reset),
      .ex_bus         (ex_bus.slave),
      .regfile        (regfile),
      .rflags_seq     (rflags_seq),
      .redirect_valid (redirect_valid),
      .redirect_rip   (redirect_rip),
      .sim_end        (sim_end),
      .retired_count  (retired_count)
`ifdef WB_BYPASS_EN
      ,
      .fwd_valid      (fwd_valid),
      .fwd_reg        (fwd_reg),
      .fwd_data       (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   // Count cycles in which the resteer pulse is high.
   always @(negedge clk) begin
      if (redirect_valid) redirect_pulses <= redirect_pulses + 1;
   end

   typedef struct {
      exwb_entry_t e;
      int          idx;
      logic [63:0] exp_val;
      logic [63:0] exp_flags;
   } vec_t;

   function automatic exwb_entry_t mk(input logic [7:0] opc, input logic [1:0] dep,
                                      input logic [3:0] rb, input logic [3:0] mb,
                                      input logic en, input logic jf, input logic fv,
                                      input logic [63:0] fl, input logic [63:0] rip,
                                      input logic se, input logic [63:0] res,
                                      input logic [63:0] ext);
      exwb_entry_t e;
      e.opcode = opc; e.dep = dep; e.reg_byte = rb; e.rm_byte = mb;
      e.enable_writeback = en; e.jump_flag = jf; e.flags_valid = fv;
      e.rflags = fl; e.rip = rip; e.sim_end = se;
      e.alu_result = res; e.alu_ext_result = ext;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Present one entry starting at a negedge; returns at a negedge.
   task automatic applyStimulus(input exwb_entry_t e, input int budget, output bit accepted);
      ex_bus.ex_valid            = 1'b1;
      ex_bus.ex_enable_writeback = e.enable_writeback;
      ex_bus.ex_jump_flag        = e.jump_flag;
      ex_bus.ex_flags_valid      = e.flags_valid;
      ex_bus.ex_rflags           = e.rflags;
      ex_bus.ex_rip              = e.rip;
      ex_bus.ex_dep              = e.dep;
      ex_bus.ex_sim_end          = e.sim_end;
      ex_bus.ex_alu_result       = e.alu_result;
      ex_bus.ex_alu_ext_result   = e.alu_ext_result;
      ex_bus.ex_regByte          = e.reg_byte;
      ex_bus.ex_rmByte           = e.rm_byte;
      ex_bus.ex_opcode           = e.opcode;
      accepted = 0;
      for (int t = 0; t < budget && !accepted; t++) begin
         if (ex_bus.ex_ready) accepted = 1;
         else saw_stall = 1;
         @(posedge clk);
         @(negedge clk);
      end
      ex_bus.ex_valid = 1'b0;
   endtask

   task automatic push(input string name, input exwb_entry_t e);
      bit acc;
      applyStimulus(e, 20, acc);
      checkOutput(name, 64'(acc), 64'd1);
   endtask

   task automatic applyReset();
      ex_bus.ex_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [63:0] norm_flags(input logic [63:0] f);
      return (f | 64'h2) & ~64'h28;
   endfunction

   vec_t        vecs [7];
   logic [63:0] m_regs [NREGS];
   logic [63:0] m_flags;
   logic [63:0] m_ret;
   logic [63:0] m_rip;
   int          m_taken;
   logic [7:0]  alu_ops [4];

   initial begin
      bit          acc;
      exwb_entry_t e;
      int          pick;
      int          d;

      ex_bus.ex_valid = 1'b0;
      alu_ops = '{8'h01, 8'h29, 8'hB8, 8'h39};

      vecs[0] = '{mk(8'hB8, 2'd0, 4'd0, 4'd3, 1, 0, 0, 64'h0, 64'h0, 0, 64'h1234, 64'h0), 3, 64'h1234, 64'h2};
      vecs[1] = '{mk(8'h01, 2'd2, 4'd5, 4'd9, 1, 0, 0, 64'h0, 64'h0, 0, 64'hDEAD_BEEF, 64'h0), 5, 64'hDEAD_BEEF, 64'h2};
      vecs[2] = '{mk(8'h01, 2'd0, 4'd5, 4'd9, 0, 0, 0, 64'h0, 64'h0, 0, 64'hFFFF, 64'h0), 9, 64'h0, 64'h2};
      vecs[3] = '{mk(8'h39, 2'd0, 4'd1, 4'd9, 0, 0, 1, 64'h40, 64'h0, 0, 64'h7, 64'h0), 9, 64'h0, 64'h42};
      vecs[4] = '{mk(8'h01, 2'd0, 4'd1, 4'd15, 1, 0, 1, 64'h8FD, 64'h0, 0, 64'h5555, 64'h0), 15, 64'h5555, 64'h8D7};
      vecs[5] = '{mk(8'h7D, 2'd0, 4'd1, 4'd4, 1, 0, 0, 64'h0, 64'h500, 0, 64'h77, 64'h0), 4, 64'h0, 64'h8D7};
      vecs[6] = '{mk(8'h74, 2'd0, 4'd1, 4'd6, 1, 0, 0, 64'h0, 64'h600, 0, 64'h66, 64'h0), 6, 64'h0, 64'h8D7};

      // Reset state
      applyReset();
      for (int i = 0; i < NREGS; i++) checkOutput($sformatf("rst_reg%0d", i), regfile[i], 64'h0);
      checkOutput("rst_rflags", rflags_seq, 64'h2);
      checkOutput("rst_retired", retired_count, 64'h0);
      checkOutput("rst_redirect", 64'(redirect_valid), 64'h0);
      checkOutput("rst_redirect_rip", redirect_rip, 64'h0);
      checkOutput("rst_sim_end", 64'(sim_end), 64'h0);
      checkOutput("rst_ready", 64'(ex_bus.ex_ready), 64'h1);

      // Mov-imm latency: visible one edge after acceptance
      push("t1_accept", mk(8'hB8, 2'd0, 4'd0, 4'd3, 1, 0, 0, 64'h0, 64'h0, 0, 64'h1234, 64'h0));
      checkOutput("t1_not_yet", regfile[3], 64'h0);
      @(negedge clk);
      checkOutput("t1_reg3", regfile[3], 64'h1234);
      checkOutput("t1_retired", retired_count, 64'd1);

      // IMUL: RAX after one edge, RDX after two, retires once
      push("t2_accept", mk(8'hF7, 2'd0, 4'd0, 4'd0, 1, 0, 0, 64'h0, 64'h0, 0, 64'hA, 64'hB));
      @(negedge clk);
      checkOutput("t2_rax", regfile[0], 64'hA);
      checkOutput("t2_rdx_pending", regfile[2], 64'h0);
      checkOutput("t2_retired_mid", retired_count, 64'd1);
      @(negedge clk);
      checkOutput("t2_rdx", regfile[2], 64'hB);
      checkOutput("t2_retired", retired_count, 64'd2);

      // Back-pressure behind an IMUL, in-order retirement
      saw_stall = 0;
      push("t3_imul", mk(8'hF7, 2'd0, 4'd0, 4'd0, 1, 0, 0, 64'h0, 64'h0, 0, 64'h111, 64'h222));
      push("t3_e1", mk(8'hB8, 2'd0, 4'd0, 4'd7, 1, 0, 0, 64'h0, 64'h0, 0, 64'h1, 64'h0));
      push("t3_e2", mk(8'hB8, 2'd0, 4'd0, 4'd7, 1, 0, 0, 64'h0, 64'h0, 0, 64'h2, 64'h0));
      push("t3_e3", mk(8'hB8, 2'd0, 4'd0, 4'd12, 1, 0, 0, 64'h0, 64'h0, 0, 64'hC, 64'h0));
      repeat (6) @(negedge clk);
      checkOutput("t3_stall_seen", 64'(saw_stall), 64'h1);
      checkOutput("t3_rax", regfile[0], 64'h111);
      checkOutput("t3_rdx", regfile[2], 64'h222);
      checkOutput("t3_reg7_order", regfile[7], 64'h2);
      checkOutput("t3_reg12", regfile[12], 64'hC);
      checkOutput("t3_retired", retired_count, 64'd6);

      // Vector table: single entries applied into an idle stage
      applyReset();
      for (int v = 0; v < 7; v++) begin
         push($sformatf("vec%0d_accept", v), vecs[v].e);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_reg", v), regfile[vecs[v].idx], vecs[v].exp_val);
         checkOutput($sformatf("vec%0d_flags", v), rflags_seq, vecs[v].exp_flags);
         checkOutput($sformatf("vec%0d_noredirect", v), 64'(redirect_valid), 64'h0);
      end
      checkOutput("vec_retired", retired_count, 64'd7);

      // Taken JE: one redirect pulse, same-edge younger entry flushed
      applyReset();
      push("t4_je", mk(8'h74, 2'd0, 4'd0, 4'd13, 1, 1, 0, 64'h0, 64'h4000, 0, 64'h99, 64'h0));
      checkOutput("t4_redirect_early", 64'(redirect_valid), 64'h0);
      push("t4_alu", mk(8'h01, 2'd0, 4'd0, 4'd11, 1, 0, 0, 64'h0, 64'h0, 0, 64'hAA, 64'h0));
      checkOutput("t4_redirect", 64'(redirect_valid), 64'h1);
      checkOutput("t4_redirect_rip", redirect_rip, 64'h4000);
      @(negedge clk);
      checkOutput("t4_redirect_drop", 64'(redirect_valid), 64'h0);
      repeat (3) @(negedge clk);
      checkOutput("t4_reg11", regfile[11], 64'h0);
      checkOutput("t4_reg13", regfile[13], 64'h0);
      checkOutput("t4_retired", retired_count, 64'd1);

      // Flags update then sim_end with a discarded follower
      applyReset();
      push("t5_cmp", mk(8'h39, 2'd0, 4'd0, 4'd1, 0, 0, 1, 64'h40, 64'h0, 0, 64'h0, 64'h0));
      @(negedge clk);
      checkOutput("t5_rflags", rflags_seq, 64'h42);
      push("t5_end", mk(8'hB8, 2'd0, 4'd0, 4'd8, 1, 0, 0, 64'h0, 64'h0, 1, 64'h99, 64'h0));
      push("t5_follow", mk(8'hB8, 2'd0, 4'd0, 4'd9, 1, 0, 0, 64'h0, 64'h0, 0, 64'h55, 64'h0));
      checkOutput("t5_sim_end", 64'(sim_end), 64'h1);
      checkOutput("t5_ready", 64'(ex_bus.ex_ready), 64'h0);
      checkOutput("t5_reg8", regfile[8], 64'h99);
      applyStimulus(mk(8'hB8, 2'd0, 4'd0, 4'd10, 1, 0, 0, 64'h0, 64'h0, 0, 64'h33, 64'h0), 4, acc);
      checkOutput("t5_blocked", 64'(acc), 64'h0);
      checkOutput("t5_reg9", regfile[9], 64'h0);
      checkOutput("t5_reg10", regfile[10], 64'h0);
      checkOutput("t5_retired", retired_count, 64'd2);
      checkOutput("t5_sticky", 64'(sim_end), 64'h1);

      // Reset between IMUL halves
      applyReset();
      push("t6_imul", mk(8'hF7, 2'd0, 4'd0, 4'd0, 1, 0, 1, 64'hC1, 64'h0, 0, 64'hA, 64'hB));
      @(negedge clk);
      checkOutput("t6_rax_lo", regfile[0], 64'hA);
      reset = 1'b0;
      #1;
      checkOutput("t6_rst_rax", regfile[0], 64'h0);
      checkOutput("t6_rst_rflags", rflags_seq, 64'h2);
      checkOutput("t6_rst_retired", retired_count, 64'h0);
      checkOutput("t6_rst_redirect", 64'(redirect_valid), 64'h0);
      checkOutput("t6_rst_sim_end", 64'(sim_end), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("t6_rdx", regfile[2], 64'h0);
      checkOutput("t6_retired", retired_count, 64'h0);
      checkOutput("t6_ready", 64'(ex_bus.ex_ready), 64'h1);

      // Randomized traffic against an in-order architectural model
      applyReset();
      redirect_pulses = 0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_flags = 64'h2; m_ret = '0; m_rip = '0; m_taken = 0;
      for (int n = 0; n < 150; n++) begin
         pick = $urandom_range(0, 9);
         e = mk(alu_ops[$urandom_range(0, 3)], ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, 0,
                {$urandom, $urandom}, {$urandom, $urandom});
         if (pick < 2) e.opcode = OPC_IMUL;
         else if (pick == 2) e.opcode = OPC_JE;
         else if (pick == 3) e.opcode = OPC_JNL;
         applyStimulus(e, 20, acc);
         checkOutput("rand_accept", 64'(acc), 64'h1);
         if (acc) begin
            d = (e.dep == 2'd2) ? int'(e.reg_byte) : int'(e.rm_byte);
            if (e.opcode == OPC_IMUL) begin
               m_regs[0] = e.alu_result;
               m_regs[2] = e.alu_ext_result;
            end else if (e.opcode != OPC_JE && e.opcode != OPC_JNL && e.enable_writeback) begin
               m_regs[d] = e.alu_result;
            end
            if (e.flags_valid) m_flags = norm_flags(e.rflags);
            if (e.opcode == OPC_JE && e.jump_flag) begin
               m_taken++;
               m_rip = e.rip;
            end
            m_ret++;
         end
         if (e.opcode == OPC_JE && e.jump_flag) repeat (5) @(negedge clk);
         else if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      for (int i = 0; i < NREGS; i++) checkOutput($sformatf("rand_reg%0d", i), regfile[i], m_regs[i]);
      checkOutput("rand_rflags", rflags_seq, m_flags);
      checkOutput("rand_retired", retired_count, m_ret);
      checkOutput("rand_redirects", 64'(redirect_pulses), 64'(m_taken));
      checkOutput("rand_redirect_rip", redirect_rip, m_rip);
      checkOutput("rand_no_end", 64'(sim_end), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
